ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX stage with EX/MEM pipeline register: single-cycle ALU, branch/jump resolution,
// and a 32-step shift-add multiplier that stalls the front end while it runs.
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic [5:0]  ALUOp,
  input  logic        RegDst,
  input  logic        ALUSrc,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Jal,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] SignExtendOutput,
  input  logic [31:0] Add_4,
  input  logic [31:0] JumpAddress,
  input  logic [4:0]  EX_Ins_A,
  input  logic [4:0]  EX_Ins_B,
  input  logic [4:0]  shamt,
  output logic        stall,
  output logic [31:0] ALUResult_Out,
  output logic [31:0] WriteData_Out,
  output logic [4:0]  WriteReg_Out,
  output logic        RegWrite_Out,
  output logic        MemRead_Out,
  output logic        MemWrite_Out,
  output logic        MemtoReg_Out,
  output logic        BranchTaken_Out,
  output logic        Jump_Out,
  output logic [31:0] BranchTarget_Out,
  output logic [31:0] JumpAddress_Out
);

  localparam int unsigned DW  = 32;
  localparam int unsigned RW  = 5;
  localparam int unsigned OPW = 6;
  localparam logic [OPW-1:0] OP_MUL   = OPW'(10);
  localparam logic [RW-1:0]  LINK_REG = RW'(31);
  localparam logic [RW-1:0]  LAST_CNT = RW'(31);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic [RW-1:0] wreg;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          btaken;
    logic          jump;
    logic [DW-1:0] btarget;
    logic [DW-1:0] jaddr;
  } exmem_t;

  state_e        state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  exmem_t        exmem_q, exmem_d, held_q, held_d, norm_c, bubble_c;
  logic [DW-1:0] op_b_c, alu_c;

  // Single-cycle datapath result for the instruction currently in EX
  always_comb begin
    op_b_c = ALUSrc ? SignExtendOutput : ReadData2;
    alu_c  = '0;
    case (ALUOp)
      OPW'(0): alu_c = ReadData1 + op_b_c;
      OPW'(1): alu_c = ReadData1 - op_b_c;
      OPW'(2): alu_c = ReadData1 & op_b_c;
      OPW'(3): alu_c = ReadData1 | op_b_c;
      OPW'(4): alu_c = ReadData1 ^ op_b_c;
      OPW'(5): alu_c = ~(ReadData1 | op_b_c);
      OPW'(6): alu_c = DW'($signed(ReadData1) < $signed(op_b_c));
      OPW'(7): alu_c = op_b_c << shamt;
      OPW'(8): alu_c = op_b_c >> shamt;
      OPW'(9): alu_c = op_b_c << 16;
      default: alu_c = '0;
    endcase
    norm_c.alu      = Jal ? Add_4 : alu_c;
    norm_c.wdata    = ReadData2;
    norm_c.wreg     = Jal ? LINK_REG : (RegDst ? EX_Ins_B : EX_Ins_A);
    norm_c.regwrite = RegWrite;
    norm_c.memread  = MemRead;
    norm_c.memwrite = MemWrite;
    norm_c.memtoreg = MemtoReg;
    norm_c.btaken   = Branch & (ReadData1 == ReadData2);
    norm_c.jump     = Jump;
    norm_c.btarget  = Add_4 + (SignExtendOutput << 2);
    norm_c.jaddr    = JumpAddress;
  end

  // Multiply FSM and EX/MEM next-state; enable gates everything, then flush, then the FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    held_d   = held_q;
    exmem_d  = exmem_q;

    bubble_c          = exmem_q;
    bubble_c.regwrite = 1'b0;
    bubble_c.memread  = 1'b0;
    bubble_c.memwrite = 1'b0;
    bubble_c.memtoreg = 1'b0;
    bubble_c.btaken   = 1'b0;
    bubble_c.jump     = 1'b0;

    stall = reset && !(enable && flush) &&
            ((state_q == BUSY) || (state_q == IDLE && ALUOp == OP_MUL && enable));

    if (enable) begin
      if (flush) begin
        state_d = IDLE;
        exmem_d = bubble_c;
      end else begin
        case (state_q)
          IDLE: begin
            if (ALUOp == OP_MUL) begin
              state_d  = BUSY;
              cnt_d    = '0;
              acc_d    = '0;
              mcand_d  = ReadData1;
              mplier_d = op_b_c;
              held_d   = norm_c;
              exmem_d  = bubble_c;
            end else begin
              exmem_d = norm_c;
            end
          end
          BUSY: begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : DW'(0));
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + RW'(1);
            exmem_d  = bubble_c;
            if (cnt_q == LAST_CNT) state_d = DONE;
          end
          DONE: begin
            exmem_d     = held_q;
            exmem_d.alu = acc_q;
            state_d     = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      held_q   <= '0;
      exmem_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      held_q   <= held_d;
      exmem_q  <= exmem_d;
    end
  end

  assign ALUResult_Out    = exmem_q.alu;
  assign WriteData_Out    = exmem_q.wdata;
  assign WriteReg_Out     = exmem_q.wreg;
  assign RegWrite_Out     = exmem_q.regwrite;
  assign MemRead_Out      = exmem_q.memread;
  assign MemWrite_Out     = exmem_q.memwrite;
  assign MemtoReg_Out     = exmem_q.memtoreg;
  assign BranchTaken_Out  = exmem_q.btaken;
  assign Jump_Out         = exmem_q.jump;
  assign BranchTarget_Out = exmem_q.btarget;
  assign JumpAddress_Out  = exmem_q.jaddr;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: ALU ops, branch/jal, multiply stall,
// enable hold, flush and asynchronous reset during a multiply.
module tb_ex_mem_stage;

  logic        clk, reset, enable, flush;
  logic [5:0]  ALUOp;
  logic        RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch, Jump, Jal;
  logic [31:0] ReadData1, ReadData2, SignExtendOutput, Add_4, JumpAddress;
  logic [4:0]  EX_Ins_A, EX_Ins_B, shamt;
  logic        stall;
  logic [31:0] ALUResult_Out, WriteData_Out, BranchTarget_Out, JumpAddress_Out;
  logic [4:0]  WriteReg_Out;
  logic        RegWrite_Out, MemRead_Out, MemWrite_Out, MemtoReg_Out, BranchTaken_Out, Jump_Out;

  int n_cmp = 0;
  int n_bad = 0;
  int scnt, rwcnt;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .ALUOp(ALUOp),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .Branch(Branch), .Jump(Jump), .Jal(Jal),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExtendOutput(SignExtendOutput),
    .Add_4(Add_4), .JumpAddress(JumpAddress), .EX_Ins_A(EX_Ins_A), .EX_Ins_B(EX_Ins_B),
    .shamt(shamt), .stall(stall), .ALUResult_Out(ALUResult_Out), .WriteData_Out(WriteData_Out),
    .WriteReg_Out(WriteReg_Out), .RegWrite_Out(RegWrite_Out), .MemRead_Out(MemRead_Out),
    .MemWrite_Out(MemWrite_Out), .MemtoReg_Out(MemtoReg_Out), .BranchTaken_Out(BranchTaken_Out),
    .Jump_Out(Jump_Out), .BranchTarget_Out(BranchTarget_Out), .JumpAddress_Out(JumpAddress_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    ALUOp = '0; RegDst = 0; ALUSrc = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
    MemtoReg = 0; Branch = 0; Jump = 0; Jal = 0; ReadData1 = '0; ReadData2 = '0;
    SignExtendOutput = '0; Add_4 = '0; JumpAddress = '0; EX_Ins_A = '0; EX_Ins_B = '0;
    shamt = '0;
  endtask

  // Runs a multiply already presented on the inputs until stall drops (DONE cycle),
  // optionally dropping enable for 5 edges starting at loop index pause_at.
  task automatic run_mul(input int pause_at, output int s, output int rw);
    s = 0;
    rw = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!stall) break;
      s++;
      if (pause_at >= 0 && i == pause_at) enable = 1'b0;
      if (pause_at >= 0 && i == pause_at + 5) enable = 1'b1;
      @(posedge clk);
      #1;
      if (RegWrite_Out) rw++;
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; flush = 1'b0;
    set_nop();
    ALUOp = 6'd10;
    #3;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_alu", ALUResult_Out, 32'd0);
    chk("reset_regwrite", 32'(RegWrite_Out), 32'd0);
    chk("reset_btarget", BranchTarget_Out, 32'd0);
    ALUOp = 6'd0;
    @(negedge clk);
    reset = 1'b1;

    // ADD with load-style control passthrough
    ReadData1 = 32'd5; ReadData2 = 32'd7; RegDst = 1; EX_Ins_B = 5'd3; EX_Ins_A = 5'd9;
    RegWrite = 1; MemRead = 1; MemtoReg = 1;
    tick();
    chk("add_result", ALUResult_Out, 32'd12);
    chk("add_wreg", 32'(WriteReg_Out), 32'd3);
    chk("add_regwrite", 32'(RegWrite_Out), 32'd1);
    chk("add_wdata", WriteData_Out, 32'd7);
    chk("add_memread", 32'(MemRead_Out), 32'd1);
    chk("add_memtoreg", 32'(MemtoReg_Out), 32'd1);
    MemRead = 0; MemtoReg = 0;

    ALUOp = 6'd1; RegDst = 0;
    tick();
    chk("sub_wrap", ALUResult_Out, 32'hFFFF_FFFE);
    chk("sub_wreg_rt", 32'(WriteReg_Out), 32'd9);

    ALUOp = 6'd6; ReadData1 = 32'hFFFF_FFFD; ReadData2 = 32'd2;
    tick();
    chk("slt_signed", ALUResult_Out, 32'd1);

    ALUOp = 6'd7; ALUSrc = 1; SignExtendOutput = 32'd3; shamt = 5'd4;
    tick();
    chk("sll_imm", ALUResult_Out, 32'h30);

    ALUOp = 6'd8; SignExtendOutput = 32'h8000_0000; shamt = 5'd31;
    tick();
    chk("srl", ALUResult_Out, 32'd1);

    ALUOp = 6'd9; SignExtendOutput = 32'h1234;
    tick();
    chk("lui", ALUResult_Out, 32'h1234_0000);

    ALUOp = 6'd5; ALUSrc = 0; ReadData1 = 32'hF0F0_F0F0; ReadData2 = 32'h0F0F_0000;
    tick();
    chk("nor", ALUResult_Out, 32'h0000_0F0F);

    ALUOp = 6'd15;
    tick();
    chk("undef_op", ALUResult_Out, 32'd0);

    // BEQ taken with negative offset, then not taken
    ALUOp = 6'd1; RegWrite = 0; Branch = 1; ReadData1 = 32'd9; ReadData2 = 32'd9;
    Add_4 = 32'h100; SignExtendOutput = 32'hFFFF_FFFF;
    tick();
    chk("beq_taken", 32'(BranchTaken_Out), 32'd1);
    chk("beq_target", BranchTarget_Out, 32'hFC);
    chk("beq_regwrite", 32'(RegWrite_Out), 32'd0);
    ReadData2 = 32'd8;
    tick();
    chk("beq_not_taken", 32'(BranchTaken_Out), 32'd0);

    // JAL
    Branch = 0; Jal = 1; Jump = 1; ALUOp = 6'd0; Add_4 = 32'h40;
    JumpAddress = 32'h0040_0000; RegWrite = 1;
    tick();
    chk("jal_result", ALUResult_Out, 32'h40);
    chk("jal_wreg", 32'(WriteReg_Out), 32'd31);
    chk("jal_jump", 32'(Jump_Out), 32'd1);
    chk("jal_jaddr", JumpAddress_Out, 32'h0040_0000);

    // enable=0 overrides flush and new inputs
    enable = 0; flush = 1; Jal = 0; Jump = 0; ReadData1 = 32'd1; ReadData2 = 32'd1;
    tick();
    chk("hold_result", ALUResult_Out, 32'h40);
    chk("hold_jump", 32'(Jump_Out), 32'd1);
    enable = 1; flush = 0;

    // MUL 0x10000 * 0x10001
    set_nop();
    ALUOp = 6'd10; ReadData1 = 32'h1_0000; ReadData2 = 32'h1_0001; RegDst = 1;
    EX_Ins_B = 5'd5; RegWrite = 1;
    #1;
    chk("mul_start_stall", 32'(stall), 32'd1);
    run_mul(-1, scnt, rwcnt);
    chk("mul_stall_cycles", 32'(scnt), 32'd33);
    chk("mul_bubbles", 32'(rwcnt), 32'd0);
    tick();
    chk("mul_result", ALUResult_Out, 32'h0001_0000);
    chk("mul_regwrite", 32'(RegWrite_Out), 32'd1);
    chk("mul_wreg", 32'(WriteReg_Out), 32'd5);
    set_nop();
    #1;
    chk("mul_idle_stall", 32'(stall), 32'd0);
    tick();
    chk("mul_write_once", 32'(RegWrite_Out), 32'd0);

    // MUL with immediate operand and a 5-cycle enable gap
    ALUOp = 6'd10; ReadData1 = 32'hFFFF_FFFF; ALUSrc = 1; SignExtendOutput = 32'd3;
    RegDst = 1; EX_Ins_B = 5'd6; RegWrite = 1;
    run_mul(10, scnt, rwcnt);
    chk("mulp_stall_cycles", 32'(scnt), 32'd38);
    chk("mulp_bubbles", 32'(rwcnt), 32'd0);
    tick();
    chk("mulp_result", ALUResult_Out, 32'hFFFF_FFFD);
    chk("mulp_regwrite", 32'(RegWrite_Out), 32'd1);
    set_nop();
    tick();

    // Reset during BUSY
    ALUOp = 6'd10; ReadData1 = 32'h1_0000; ReadData2 = 32'h1_0001; RegWrite = 1;
    for (int i = 0; i < 11; i++) tick();
    chk("rst_busy_stall_pre", 32'(stall), 32'd1);
    reset = 0;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_alu", ALUResult_Out, 32'd0);
    chk("rst_mid_jaddr", JumpAddress_Out, 32'd0);
    chk("rst_mid_wreg", 32'(WriteReg_Out), 32'd0);
    set_nop();
    ReadData1 = 32'd5; ReadData2 = 32'd7; RegDst = 1; EX_Ins_B = 5'd3; RegWrite = 1;
    @(negedge clk);
    reset = 1;
    #1;
    chk("rst_after_stall", 32'(stall), 32'd0);
    tick();
    chk("rst_add_result", ALUResult_Out, 32'd12);
    chk("rst_add_regwrite", 32'(RegWrite_Out), 32'd1);
    chk("rst_add_wreg", 32'(WriteReg_Out), 32'd3);

    // Flush during BUSY
    ALUOp = 6'd10; ReadData1 = 32'd7; ReadData2 = 32'd6;
    for (int i = 0; i < 5; i++) tick();
    chk("flush_pre_stall", 32'(stall), 32'd1);
    flush = 1;
    #1;
    chk("flush_stall", 32'(stall), 32'd0);
    tick();
    chk("flush_bubble_rw", 32'(RegWrite_Out), 32'd0);
    chk("flush_data_kept", ALUResult_Out, 32'd12);
    flush = 0; ALUOp = 6'd0; ReadData1 = 32'd2; ReadData2 = 32'd3;
    #1;
    chk("flush_idle_stall", 32'(stall), 32'd0);
    tick();
    chk("flush_next_add", ALUResult_Out, 32'd5);
    chk("flush_next_rw", 32'(RegWrite_Out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
